// File: rtl/trdb_stream_fifo.sv
// Word buffer between the trace byte aligner and the bus-side consumer.
// Latency: first-word fall-through, a word written at edge N is the head in the cycle after N.
// Backpressure: none upstream (words arriving while full are dropped and counted); consumer stalls via ready_i.

package trdb_pkg;
  localparam int unsigned BUS_DATA_WIDTH = 32;
endpackage

module trdb_stream_fifo #(
  parameter int unsigned DATA_WIDTH = trdb_pkg::BUS_DATA_WIDTH,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned THRESHOLD  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic                    valid_i,
  input  logic                    flush_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [$clog2(DEPTH):0]  fill_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    overflow_o,
  output logic [15:0]             drop_cnt_o,
  output logic                    thresh_irq_o,
  output logic                    flush_done_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [AW:0] THR_L = PW'(THRESHOLD);

  typedef enum logic {Run, Drain} state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]           wptr_q, rptr_q;
  logic [AW:0]           fill_q, fill_d;
  logic                  overflow_q;
  logic [15:0]           drop_cnt_q;
  logic                  irq_q;
  logic                  done_q;
  state_e                state_q;

  logic full, empty, push, pop, drop;

  // Status decodes depend on the registered pointers only, never on valid_i/ready_i.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign pop  = !empty && ready_i;
  assign push = valid_i && (!full || pop);
  assign drop = valid_i && full && !pop;

  assign fill_d = fill_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  assign data_o       = empty ? '0 : mem_q[rptr_q[AW-1:0]];
  assign valid_o      = !empty;
  assign full_o       = full;
  assign empty_o      = empty;
  assign fill_o       = fill_q;
  assign overflow_o   = overflow_q;
  assign drop_cnt_o   = drop_cnt_q;
  assign thresh_irq_o = irq_q;
  assign flush_done_o = done_q;

  // Storage array: written on accepted pushes, never reset (contents are masked when empty).
  always_ff @(posedge clk_i) begin
    if (push && !clear_i) begin
      mem_q[wptr_q[AW-1:0]] <= data_i;
    end
  end

  // Pointers, occupancy and overflow bookkeeping; clear wins over any traffic.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (clear_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      fill_q <= fill_d;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  // Threshold interrupt fires only on an upward crossing, so it cannot re-fire while above.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q <= 1'b0;
    end else if (clear_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (fill_q < THR_L) && (fill_d >= THR_L);
    end
  end

  // Flush tracking: remember an upstream flush until everything buffered has been consumed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Run;
      done_q  <= 1'b0;
    end else if (clear_i) begin
      state_q <= Run;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        Run: begin
          if (flush_i) begin
            if (fill_d == '0) done_q  <= 1'b1;
            else              state_q <= Drain;
          end
        end
        Drain: begin
          if (fill_d == '0) begin
            done_q  <= 1'b1;
            state_q <= Run;
          end
        end
        default: state_q <= Run;
      endcase
    end
  end

endmodule

// File: tb/tb_trdb_stream_fifo.sv
module tb_trdb_stream_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int THR   = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          clear_i;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic          flush_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic [4:0]    fill_o;
  logic          full_o;
  logic          empty_o;
  logic          overflow_o;
  logic [15:0]   drop_cnt_o;
  logic          thresh_irq_o;
  logic          flush_done_o;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [15:0]   m_drop;
  bit            m_ovf;
  bit            m_drain;
  bit            m_irq;
  bit            m_done;

  trdb_stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .THRESHOLD(THR)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .data_i(data_i), .valid_i(valid_i), .flush_i(flush_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .fill_o(fill_o), .full_o(full_o), .empty_o(empty_o),
    .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o),
    .thresh_irq_o(thresh_irq_o), .flush_done_o(flush_done_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic model_reset();
    mq.delete();
    m_drop = '0; m_ovf = 0; m_drain = 0; m_irq = 0; m_done = 0;
  endtask

  // Apply one cycle of inputs, advance the model by the documented rules, sample #1 after the edge.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r,
                       input logic f, input logic c);
    int old_sz;
    bit do_pop, do_push;
    logic [DW-1:0] tmp;
    valid_i = v; data_i = d; ready_i = r; flush_i = f; clear_i = c;
    old_sz = mq.size();
    if (c) begin
      model_reset();
    end else begin
      do_pop  = (old_sz > 0) && r;
      do_push = v && ((old_sz < DEPTH) || do_pop);
      if (do_pop)  tmp = mq.pop_front();
      if (do_push) mq.push_back(d);
      if (v && !do_push) begin
        m_ovf = 1;
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
      m_irq  = (old_sz < THR) && (mq.size() >= THR);
      m_done = 0;
      if (m_drain) begin
        if (mq.size() == 0) begin m_done = 1; m_drain = 0; end
      end else if (f) begin
        if (mq.size() == 0) m_done = 1;
        else                m_drain = 1;
      end
    end
    @(posedge clk_i);
    #1;
    valid_i = 0; data_i = '0; ready_i = 0; flush_i = 0; clear_i = 0;
  endtask

  task automatic test_reset();
    rst_ni = 0; clear_i = 0; data_i = '0; valid_i = 0; flush_i = 0; ready_i = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    total++; if (data_o !== 32'h0 || valid_o !== 1'b0) begin bad++;
      $display("FAIL reset_data: data_o=%h valid_o=%b, want 0/0", data_o, valid_o); end
    total++; if (fill_o !== 5'd0 || full_o !== 1'b0 || empty_o !== 1'b1) begin bad++;
      $display("FAIL reset_fill: fill=%0d full=%b empty=%b, want 0/0/1", fill_o, full_o, empty_o); end
    total++; if (overflow_o !== 1'b0 || drop_cnt_o !== 16'd0) begin bad++;
      $display("FAIL reset_ovf: ovf=%b drop=%0d, want 0/0", overflow_o, drop_cnt_o); end
    total++; if (thresh_irq_o !== 1'b0 || flush_done_o !== 1'b0) begin bad++;
      $display("FAIL reset_pulses: irq=%b done=%b, want 0/0", thresh_irq_o, flush_done_o); end
    rst_ni = 1;
    cycle(0, '0, 0, 0, 0);
  endtask

  task automatic test_basic_order();
    logic [DW-1:0] w [3];
    w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      cycle(1, w[i], 0, 0, 0);
      total++; if (fill_o !== 5'(i + 1)) begin bad++;
        $display("FAIL basic_fill%0d: fill=%0d, want %0d", i, fill_o, i + 1); end
      if (i == 0) begin
        total++; if (valid_o !== 1'b1 || data_o !== 32'h11) begin bad++;
          $display("FAIL basic_fwft: valid=%b data=%h, want 1/11", valid_o, data_o); end
      end
    end
    for (int i = 0; i < 3; i++) begin
      total++; if (data_o !== w[i] || valid_o !== 1'b1) begin bad++;
        $display("FAIL basic_head%0d: data=%h valid=%b, want %h/1", i, data_o, valid_o, w[i]); end
      cycle(0, '0, 1, 0, 0);
    end
    total++; if (empty_o !== 1'b1 || data_o !== 32'h0) begin bad++;
      $display("FAIL basic_empty: empty=%b data=%h, want 1/0", empty_o, data_o); end
  endtask

  task automatic test_overflow();
    cycle(0, '0, 0, 0, 1);
    for (int i = 0; i < 18; i++) begin
      cycle(1, DW'(i), 0, 0, 0);
      if (i == 15) begin
        total++; if (full_o !== 1'b1 || drop_cnt_o !== 16'd0 || fill_o !== 5'd16) begin bad++;
          $display("FAIL ovf_full: full=%b drop=%0d fill=%0d, want 1/0/16", full_o, drop_cnt_o, fill_o); end
      end
    end
    total++; if (drop_cnt_o !== 16'd2 || overflow_o !== 1'b1 || fill_o !== 5'd16) begin bad++;
      $display("FAIL ovf_drop: drop=%0d ovf=%b fill=%0d, want 2/1/16", drop_cnt_o, overflow_o, fill_o); end
    for (int i = 0; i < 16; i++) begin
      total++; if (data_o !== DW'(i)) begin bad++;
        $display("FAIL ovf_order%0d: data=%h, want %h", i, data_o, i); end
      cycle(0, '0, 1, 0, 0);
    end
    total++; if (empty_o !== 1'b1 || overflow_o !== 1'b1 || drop_cnt_o !== 16'd2) begin bad++;
      $display("FAIL ovf_after: empty=%b ovf=%b drop=%0d, want 1/1/2", empty_o, overflow_o, drop_cnt_o); end
  endtask

  task automatic test_full_push_pop();
    cycle(0, '0, 0, 0, 1);
    for (int i = 0; i < 16; i++) cycle(1, DW'(i), 0, 0, 0);
    for (int i = 16; i < 20; i++) begin
      cycle(1, DW'(i), 1, 0, 0);
      total++; if (fill_o !== 5'd16 || drop_cnt_o !== 16'd0 || full_o !== 1'b1) begin bad++;
        $display("FAIL fpp_hold%0d: fill=%0d drop=%0d full=%b, want 16/0/1", i, fill_o, drop_cnt_o, full_o); end
    end
    for (int i = 4; i < 20; i++) begin
      total++; if (data_o !== DW'(i)) begin bad++;
        $display("FAIL fpp_order%0d: data=%h, want %h", i, data_o, i); end
      cycle(0, '0, 1, 0, 0);
    end
  endtask

  task automatic test_threshold();
    int pulses;
    cycle(0, '0, 0, 0, 1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1, DW'(i + 32'h100), 0, 0, 0);
      if (thresh_irq_o === 1'b1) pulses++;
      total++; if (thresh_irq_o !== (i == 7)) begin bad++;
        $display("FAIL thr_pulse%0d: irq=%b, want %b", i, thresh_irq_o, (i == 7)); end
    end
    cycle(0, '0, 0, 0, 0);
    if (thresh_irq_o === 1'b1) pulses++;
    total++; if (pulses != 1) begin bad++;
      $display("FAIL thr_count: pulses=%0d, want 1", pulses); end
    cycle(0, '0, 1, 0, 0);
    total++; if (thresh_irq_o !== 1'b0 || fill_o !== 5'd7) begin bad++;
      $display("FAIL thr_pop: irq=%b fill=%0d, want 0/7", thresh_irq_o, fill_o); end
    cycle(1, 32'hAA, 0, 0, 0);
    total++; if (thresh_irq_o !== 1'b1) begin bad++;
      $display("FAIL thr_recross: irq=%b, want 1", thresh_irq_o); end
    cycle(1, 32'hBB, 0, 0, 0);
    total++; if (thresh_irq_o !== 1'b0 || fill_o !== 5'd9) begin bad++;
      $display("FAIL thr_ninth: irq=%b fill=%0d, want 0/9", thresh_irq_o, fill_o); end
  endtask

  task automatic test_flush();
    int pulses;
    cycle(0, '0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, DW'(i + 32'h200), 0, 0, 0);
    cycle(1, 32'h203, 0, 1, 0);
    total++; if (flush_done_o !== 1'b0 || fill_o !== 5'd4) begin bad++;
      $display("FAIL flush_start: done=%b fill=%0d, want 0/4", flush_done_o, fill_o); end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(0, '0, 1, 0, 0);
      if (flush_done_o === 1'b1) pulses++;
      total++; if (flush_done_o !== (i == 3)) begin bad++;
        $display("FAIL flush_pos%0d: done=%b, want %b", i, flush_done_o, (i == 3)); end
    end
    total++; if (pulses != 1) begin bad++;
      $display("FAIL flush_count: pulses=%0d, want 1", pulses); end
    cycle(0, '0, 0, 1, 0);
    total++; if (flush_done_o !== 1'b1) begin bad++;
      $display("FAIL flush_empty: done=%b, want 1", flush_done_o); end
    cycle(0, '0, 0, 0, 0);
    total++; if (flush_done_o !== 1'b0) begin bad++;
      $display("FAIL flush_empty_once: done=%b, want 0", flush_done_o); end
  endtask

  task automatic test_clear();
    cycle(0, '0, 0, 0, 1);
    for (int i = 0; i < 17; i++) cycle(1, DW'(i), 0, 0, 0);
    for (int i = 0; i < 11; i++) cycle(0, '0, 1, 0, 0);
    cycle(0, '0, 0, 1, 0);
    total++; if (fill_o !== 5'd5 || overflow_o !== 1'b1 || flush_done_o !== 1'b0) begin bad++;
      $display("FAIL clear_setup: fill=%0d ovf=%b done=%b, want 5/1/0", fill_o, overflow_o, flush_done_o); end
    cycle(1, 32'hDEAD, 0, 0, 1);
    total++; if (fill_o !== 5'd0 || valid_o !== 1'b0 || drop_cnt_o !== 16'd0 ||
                 overflow_o !== 1'b0 || flush_done_o !== 1'b0) begin bad++;
      $display("FAIL clear_state: fill=%0d valid=%b drop=%0d ovf=%b done=%b, want 0/0/0/0/0",
               fill_o, valid_o, drop_cnt_o, overflow_o, flush_done_o); end
    cycle(0, '0, 0, 0, 0);
    total++; if (flush_done_o !== 1'b0 || thresh_irq_o !== 1'b0) begin bad++;
      $display("FAIL clear_fsm: done=%b irq=%b, want 0/0", flush_done_o, thresh_irq_o); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cycle(1, DW'(i + 32'h300), 0, 0, 0);
    #2;
    rst_ni = 0;
    #1;
    total++; if (valid_o !== 1'b0 || fill_o !== 5'd0 || empty_o !== 1'b1) begin bad++;
      $display("FAIL arst: valid=%b fill=%0d empty=%b, want 0/0/1", valid_o, fill_o, empty_o); end
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1;
  endtask

  task automatic test_random();
    int rp;
    logic [DW-1:0] exp_d;
    for (int i = 0; i < 3000; i++) begin
      rp = ((i / 250) % 2 == 1) ? 80 : 25;
      cycle($urandom_range(99) < 70, $urandom, $urandom_range(99) < rp,
            $urandom_range(99) < 3, $urandom_range(299) < 1);
      exp_d = (mq.size() > 0) ? mq[0] : '0;
      total++; if (data_o !== exp_d || valid_o !== (mq.size() > 0)) begin bad++;
        $display("FAIL rnd_head@%0d: data=%h valid=%b, want %h/%b", i, data_o, valid_o, exp_d, mq.size() > 0); end
      total++; if (fill_o !== 5'(mq.size()) || full_o !== (mq.size() == DEPTH) || empty_o !== (mq.size() == 0)) begin bad++;
        $display("FAIL rnd_fill@%0d: fill=%0d full=%b empty=%b, want fill %0d", i, fill_o, full_o, empty_o, mq.size()); end
      total++; if (overflow_o !== m_ovf || drop_cnt_o !== m_drop) begin bad++;
        $display("FAIL rnd_ovf@%0d: ovf=%b drop=%0d, want %b/%0d", i, overflow_o, drop_cnt_o, m_ovf, m_drop); end
      total++; if (thresh_irq_o !== m_irq || flush_done_o !== m_done) begin bad++;
        $display("FAIL rnd_pulse@%0d: irq=%b done=%b, want %b/%b", i, thresh_irq_o, flush_done_o, m_irq, m_done); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_order();
    test_overflow();
    test_full_push_pop();
    test_threshold();
    test_flush();
    test_clear();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
